// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared sizes and types for the 8x16 register file
// Rev 1.0
// ============================================================================
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = 3'd0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// regfile_read_port : combinational address->data mux, r0 reads as zero
// Optional write-through bypass compare when REGFILE_BYPASS_EN is defined.
// Rev 1.0
// ============================================================================
module regfile_read_port #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]               addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                            byp_valid,
  input  logic [ADDR_W-1:0]               byp_addr,
  input  logic [DATA_W-1:0]               byp_data,
`endif
  output logic [DATA_W-1:0]               data
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(regfile_pkg::ZERO_REG);

  always_comb begin
    data = regs[addr];
    if (addr == ZERO_ADDR) begin
      data = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (byp_valid && (byp_addr == addr)) begin
      data = byp_data;
`endif
    end
  end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// regfile : 8x16 register file, two async read ports, one sync write port
// Optional feature macro: REGFILE_BYPASS_EN (write-through bypass). Rev 1.0
// ============================================================================
module regfile #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(regfile_pkg::ZERO_REG);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
  logic                            wr_valid;

  assign wr_valid = we3 && (a3 != ZERO_ADDR);

  always_comb begin
    regs_d = regs_q;
    if (wr_valid) begin
      regs_d[a3] = wd3;
    end
    regs_d[0] = '0;
  end

  // Reset wins over a write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_valid;
  assign byp_valid = rst_n && wr_valid;
`endif

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd1 (
    .regs      (regs_q),
    .addr      (a1),
`ifdef REGFILE_BYPASS_EN
    .byp_valid (byp_valid),
    .byp_addr  (a3),
    .byp_data  (wd3),
`endif
    .data      (rd1)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd2 (
    .regs      (regs_q),
    .addr      (a2),
`ifdef REGFILE_BYPASS_EN
    .byp_valid (byp_valid),
    .byp_addr  (a3),
    .byp_data  (wd3),
`endif
    .data      (rd2)
  );

endmodule : regfile
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// tb_regfile : directed + random checks of regfile against an array model
// Rev 1.0
// ============================================================================
module tb_regfile;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      we3;
  reg_addr_t a1, a2, a3;
  reg_data_t wd3, rd1, rd2;

  int        n_cmp = 0;
  int        n_err = 0;
  reg_data_t model [NUM_REGS];

  always #5 clk = ~clk;

  regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we3   (we3),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  task automatic chk(input string tag, input reg_data_t obs, input reg_data_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected read value from the architectural register contents.
  function automatic reg_data_t ref_read(input reg_addr_t a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (rst_n && we3 && (a3 != 0) && (a == a3)) return wd3;
`endif
    return model[a];
  endfunction

  task automatic check_ports(input string tag);
    chk({tag, "_rd1"}, rd1, ref_read(a1));
    chk({tag, "_rd2"}, rd2, ref_read(a2));
  endtask

  // Advance one edge and apply the same edge to the model.
  task automatic clock();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    end else if (we3 && (a3 != 0)) begin
      model[a3] = wd3;
    end
  endtask

  task automatic wr(input reg_addr_t a, input reg_data_t d);
    we3 = 1'b1; a3 = a; wd3 = d;
    clock();
    we3 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    rst_n = 1'b0; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
    clock();
    clock();
    rst_n = 1'b1;

    for (int i = 0; i < NUM_REGS; i++) begin
      a1 = reg_addr_t'(i); a2 = reg_addr_t'(NUM_REGS - 1 - i); #1;
      chk("reset_rd1", rd1, 16'h0000);
      chk("reset_rd2", rd2, 16'h0000);
    end

    wr(3'd1, 16'hABCD);
    a1 = 3'd1; a2 = 3'd0; #1;
    chk("wr_r1", rd1, 16'hABCD);
    chk("rd_r0", rd2, 16'h0000);

    wr(3'd2, 16'h0123);
    wr(3'd3, 16'hCCCC);
    wr(3'd1, 16'h3333);
    a1 = 3'd2; a2 = 3'd3; #1;
    chk("seq_r2", rd1, 16'h0123);
    chk("seq_r3", rd2, 16'hCCCC);
    a1 = 3'd1; a2 = 3'd1; #1;
    chk("ovw_r1_p1", rd1, 16'h3333);
    chk("ovw_r1_p2", rd2, 16'h3333);

    wr(3'd0, 16'hFFFF);
    a1 = 3'd0; #1;
    chk("r0_zero", rd1, 16'h0000);

    we3 = 1'b0; a3 = 3'd4; wd3 = 16'h5A5A;
    clock();
    a1 = 3'd4; #1;
    chk("we_off_r4", rd1, 16'h0000);

    wr(3'd5, 16'h1111);
    a1 = 3'd5; a3 = 3'd5; wd3 = 16'h2222; we3 = 1'b1; #1;
`ifdef REGFILE_BYPASS_EN
    chk("rw_before", rd1, 16'h2222);
`else
    chk("rw_before", rd1, 16'h1111);
`endif
    clock();
    we3 = 1'b0; #1;
    chk("rw_after", rd1, 16'h2222);

    rst_n = 1'b0; we3 = 1'b1; a3 = 3'd6; wd3 = 16'h7777; a1 = 3'd6; a2 = 3'd5; #1;
    chk("rst_byp_sup", rd1, 16'h0000);
    chk("rst_hold_r5", rd2, 16'h2222);
    clock();
    rst_n = 1'b1; we3 = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      a1 = reg_addr_t'(i); a2 = reg_addr_t'(i); #1;
      chk("rst_wr_rd1", rd1, 16'h0000);
      chk("rst_wr_rd2", rd2, 16'h0000);
    end

    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      we3   = ($urandom_range(0, 3) != 0);
      a1    = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      a2    = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      a3    = ($urandom_range(0, 3) == 0) ? a1 : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      wd3   = reg_data_t'($urandom);
      #1;
      check_ports("rand");
      clock();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_regfile
`default_nettype wire
